idma_mp_frontend_arbiter: RTL and testbench

Shares one Mempool iDMA midend request port between NumReq frontends, for example per-tile DMA frontends. Arbitration is round-robin with a lock held until handshake. An in-order ID FIFO records which frontend issued each transfer, so that midend responses (completed in order) return to the correct requester. The block sits between the frontends and the midend, which splits transfers into 64 KiB regions across 8 backends.

---
 rtl/idma_mp_frontend_arbiter.sv | 167 ++++++++++++++++
 tb/tb_idma_mp_frontend_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/idma_mp_frontend_arbiter.sv
// Round-robin arbiter that shares one iDMA midend request port between NumReq frontends.
// An in-order ID FIFO records the issuing frontend so that midend responses go back to it.
module idma_mp_frontend_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned LenWidth       = 32,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]     req_src_addr_i,
  input  logic [NumReq*AddrWidth-1:0]     req_dst_addr_i,
  input  logic [NumReq*LenWidth-1:0]      req_len_i,
  output logic [NumReq-1:0]               rsp_valid_o,
  input  logic [NumReq-1:0]               rsp_ready_i,
  output logic                            rsp_error_o,
  output logic [AddrWidth-1:0]            rsp_err_addr_o,
  output logic                            mid_req_valid_o,
  input  logic                            mid_req_ready_i,
  output logic [AddrWidth-1:0]            mid_src_addr_o,
  output logic [AddrWidth-1:0]            mid_dst_addr_o,
  output logic [LenWidth-1:0]             mid_len_o,
  input  logic                            mid_rsp_valid_i,
  output logic                            mid_rsp_ready_o,
  input  logic                            mid_rsp_error_i,
  input  logic [AddrWidth-1:0]            mid_rsp_err_addr_i,
  output logic                            busy_o,
  output logic [$clog2(MaxOutstanding):0] outstanding_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic {IDLE, LOCKED} state_e;

  localparam logic [IdxW:0]   NumReqW = (IdxW+1)'(NumReq);
  localparam idx_t            LastIdx = idx_t'(NumReq - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

  state_e          state_q, state_d;
  idx_t            ptr_q, ptr_d, win_q, win_d, winner, arb_idx, head;
  logic            arb_found, grant_valid, full, empty, push, pop;
  logic [IdxW:0]   cand;
  idx_t            fifo_mem [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [AddrWidth-1:0] src_arr [NumReq];
  logic [AddrWidth-1:0] dst_arr [NumReq];
  logic [LenWidth-1:0]  len_arr [NumReq];

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      src_arr[i] = req_src_addr_i[i*AddrWidth +: AddrWidth];
      dst_arr[i] = req_dst_addr_i[i*AddrWidth +: AddrWidth];
      len_arr[i] = req_len_i[i*LenWidth +: LenWidth];
    end
  end

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);

  // First valid requester at or after the priority pointer, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(i);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!arb_found && req_valid_i[cand[IdxW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    winner      = arb_idx;
    grant_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!full && arb_found) begin
          grant_valid = 1'b1;
          if (!mid_req_ready_i) begin
            state_d = LOCKED;
            win_d   = arb_idx;
          end
        end
      end
      LOCKED: begin
        winner      = win_q;
        grant_valid = 1'b1;
        if (mid_req_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so no request leaks out combinationally while rst_ni is low.
  assign mid_req_valid_o = grant_valid & rst_ni;
  assign push            = mid_req_valid_o & mid_req_ready_i;
  assign ptr_d           = (winner == LastIdx) ? '0 : winner + 1'b1;

  assign mid_src_addr_o = mid_req_valid_o ? src_arr[winner] : '0;
  assign mid_dst_addr_o = mid_req_valid_o ? dst_arr[winner] : '0;
  assign mid_len_o      = mid_req_valid_o ? len_arr[winner] : '0;

  always_comb begin
    req_ready_o         = '0;
    req_ready_o[winner] = push;
  end

  assign head            = fifo_mem[rd_ptr_q];
  assign mid_rsp_ready_o = rsp_ready_i[head] & !empty;
  assign pop             = mid_rsp_valid_i & mid_rsp_ready_o;
  assign rsp_error_o     = mid_rsp_error_i;
  assign rsp_err_addr_o  = mid_rsp_err_addr_i;

  always_comb begin
    rsp_valid_o       = '0;
    rsp_valid_o[head] = mid_rsp_valid_i & !empty;
  end

  assign busy_o        = !empty | (|req_valid_i);
  assign outstanding_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      if (push) begin
        ptr_q    <= ptr_d;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= winner;
  end

  a_locked_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCKED) |-> req_valid_i[win_q]);
  a_rsp_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mid_rsp_valid_i |-> !empty);

endmodule

// File: tb/tb_idma_mp_frontend_arbiter.sv
// Directed bench for idma_mp_frontend_arbiter: vector table plus hand-written corner sequences.
module tb_idma_mp_frontend_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 32;
  localparam int unsigned MO = 8;

  logic            clk, rst_n;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*AW-1:0] src_bus, dst_bus;
  logic [NR*LW-1:0] len_bus;
  logic            rsp_error, mid_req_valid, mid_req_ready, mid_rsp_valid, mid_rsp_ready, mid_rsp_error;
  logic [AW-1:0]   rsp_err_addr, mid_src, mid_dst, mid_rsp_err_addr;
  logic [LW-1:0]   mid_len;
  logic            busy;
  logic [3:0]      outstanding;

  logic [31:0] src_tab [NR];
  logic [31:0] dst_tab [NR];
  logic [31:0] len_tab [NR];

  int unsigned n_checks, n_errors;
  int unsigned exp_q[$];

  typedef struct {
    logic [3:0]  rv;
    logic        mrdy;
    logic        rspv;
    logic [3:0]  rrdy;
    logic        exp_mv;
    int unsigned exp_win;
    logic [3:0]  exp_rr;
    logic [3:0]  exp_rspv;
    logic        exp_mrr;
    int unsigned exp_out;
    logic        exp_busy;
  } vec_t;

  vec_t vt[$];

  idma_mp_frontend_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .LenWidth(LW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_src_addr_i(src_bus), .req_dst_addr_i(dst_bus), .req_len_i(len_bus),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_error_o(rsp_error), .rsp_err_addr_o(rsp_err_addr),
    .mid_req_valid_o(mid_req_valid), .mid_req_ready_i(mid_req_ready),
    .mid_src_addr_o(mid_src), .mid_dst_addr_o(mid_dst), .mid_len_o(mid_len),
    .mid_rsp_valid_i(mid_rsp_valid), .mid_rsp_ready_o(mid_rsp_ready),
    .mid_rsp_error_i(mid_rsp_error), .mid_rsp_err_addr_i(mid_rsp_err_addr),
    .busy_o(busy), .outstanding_o(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rv, input logic mrdy, input logic rspv,
                              input logic [3:0] rrdy, input logic exp_mv, input int unsigned exp_win,
                              input logic [3:0] exp_rr, input logic [3:0] exp_rspv, input logic exp_mrr,
                              input int unsigned exp_out, input logic exp_busy);
    vec_t v;
    v.rv = rv; v.mrdy = mrdy; v.rspv = rspv; v.rrdy = rrdy; v.exp_mv = exp_mv;
    v.exp_win = exp_win; v.exp_rr = exp_rr; v.exp_rspv = exp_rspv; v.exp_mrr = exp_mrr;
    v.exp_out = exp_out; v.exp_busy = exp_busy;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    req_valid     = v.rv;
    mid_req_ready = v.mrdy;
    mid_rsp_valid = v.rspv;
    rsp_ready     = v.rrdy;
    #1;
    chk({tag, " mid_req_valid"}, 64'(mid_req_valid), 64'(v.exp_mv));
    chk({tag, " req_ready"}, 64'(req_ready), 64'(v.exp_rr));
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(v.exp_rspv));
    chk({tag, " mid_rsp_ready"}, 64'(mid_rsp_ready), 64'(v.exp_mrr));
    chk({tag, " outstanding"}, 64'(outstanding), 64'(v.exp_out));
    chk({tag, " busy"}, 64'(busy), 64'(v.exp_busy));
    if (v.exp_mv) begin
      chk({tag, " src"}, 64'(mid_src), 64'(src_tab[v.exp_win]));
      chk({tag, " dst"}, 64'(mid_dst), 64'(dst_tab[v.exp_win]));
      chk({tag, " len"}, 64'(mid_len), 64'(len_tab[v.exp_win]));
    end
  endtask

  task automatic drain();
    int unsigned h;
    while (exp_q.size() > 0) begin
      h = exp_q.pop_front();
      run_vec(mk(4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'(1 << h), 1'b1,
                 exp_q.size() + 1, 1'b1), "drain");
    end
    run_vec(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b0, 0, 1'b0), "drained");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    src_tab[0] = 32'h0A00; dst_tab[0] = 32'h1A00; len_tab[0] = 32'h10;
    src_tab[1] = 32'h0B00; dst_tab[1] = 32'h1B00; len_tab[1] = 32'h20;
    src_tab[2] = 32'h1000; dst_tab[2] = 32'h2000; len_tab[2] = 32'h40;
    src_tab[3] = 32'h0D00; dst_tab[3] = 32'h1D00; len_tab[3] = 32'h80;
    for (int i = 0; i < NR; i++) begin
      src_bus[i*AW +: AW] = src_tab[i];
      dst_bus[i*AW +: AW] = dst_tab[i];
      len_bus[i*LW +: LW] = len_tab[i];
    end
    rst_n = 1'b0; req_valid = '0; mid_req_ready = 1'b0; mid_rsp_valid = 1'b0;
    rsp_ready = '0; mid_rsp_error = 1'b0; mid_rsp_err_addr = '0;

    // rv, mrdy, rspv, rrdy | mv, win, rr, rspv, mrr, out, busy
    vt.push_back(mk(4'b0100, 1, 0, 4'b0000, 1, 2, 4'b0100, 4'b0000, 0, 0, 1));
    vt.push_back(mk(4'b0000, 0, 1, 4'b1111, 0, 0, 4'b0000, 4'b0100, 1, 1, 1));
    vt.push_back(mk(4'b1000, 1, 0, 4'b0000, 1, 3, 4'b1000, 4'b0000, 0, 0, 1));
    vt.push_back(mk(4'b1111, 1, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 1, 1));
    vt.push_back(mk(4'b1111, 1, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 2, 1));
    vt.push_back(mk(4'b1111, 1, 0, 4'b0000, 1, 2, 4'b0100, 4'b0000, 0, 3, 1));
    vt.push_back(mk(4'b1111, 1, 0, 4'b0000, 1, 3, 4'b1000, 4'b0000, 0, 4, 1));
    vt.push_back(mk(4'b1111, 1, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 5, 1));
    vt.push_back(mk(4'b0010, 1, 1, 4'b1111, 1, 1, 4'b0010, 4'b1000, 1, 6, 1));
    vt.push_back(mk(4'b0000, 0, 1, 4'b1110, 0, 0, 4'b0000, 4'b0001, 0, 6, 1));
    vt.push_back(mk(4'b0000, 0, 1, 4'b1111, 0, 0, 4'b0000, 4'b0001, 1, 6, 1));
    vt.push_back(mk(4'b0000, 0, 1, 4'b1111, 0, 0, 4'b0000, 4'b0010, 1, 5, 1));
    vt.push_back(mk(4'b0000, 0, 1, 4'b1111, 0, 0, 4'b0000, 4'b0100, 1, 4, 1));
    vt.push_back(mk(4'b0000, 0, 1, 4'b1111, 0, 0, 4'b0000, 4'b1000, 1, 3, 1));
    vt.push_back(mk(4'b0000, 0, 1, 4'b1111, 0, 0, 4'b0000, 4'b0001, 1, 2, 1));
    vt.push_back(mk(4'b0000, 0, 1, 4'b1111, 0, 0, 4'b0000, 4'b0010, 1, 1, 1));
    vt.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));

    // Reset state
    #1;
    chk("reset mid_req_valid", 64'(mid_req_valid), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset outstanding", 64'(outstanding), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], $sformatf("t%0d", i));

    // Locked grant: pointer at 2, first move it to 1 via frontend 0
    run_vec(mk(4'b0001, 1, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 0, 1), "lk0");
    run_vec(mk(4'b0010, 0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 1, 1), "lk1");
    for (int c = 2; c <= 5; c++)
      run_vec(mk(4'b0011, 0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 1, 1), $sformatf("lk%0d", c));
    run_vec(mk(4'b0011, 1, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 1, 1), "lk6");
    run_vec(mk(4'b0001, 1, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 2, 1), "lk7");
    exp_q = '{0, 1, 0};
    drain();

    // FIFO full: pointer at 1, eight grants 1,2,3,0,1,2,3,0
    for (int c = 0; c < 8; c++)
      run_vec(mk(4'b1111, 1, 0, 4'b0000, 1, (c + 1) % 4, 4'(1 << ((c + 1) % 4)), 4'b0000, 0, c, 1),
              $sformatf("fill%0d", c));
    run_vec(mk(4'b1111, 1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8, 1), "full_block");
    run_vec(mk(4'b1111, 1, 1, 4'b1111, 0, 0, 4'b0000, 4'b0010, 1, 8, 1), "full_pop");
    run_vec(mk(4'b1111, 1, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 7, 1), "full_regrant");
    run_vec(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8, 1), "full_idle");
    exp_q = '{2, 3, 0, 1, 2, 3, 0, 1};
    drain();

    // Error response to frontend 3, held off by its ready
    run_vec(mk(4'b1000, 1, 0, 4'b0000, 1, 3, 4'b1000, 4'b0000, 0, 0, 1), "err_req");
    mid_rsp_error = 1'b1;
    mid_rsp_err_addr = 32'hDEAD0;
    for (int c = 0; c < 3; c++) begin
      run_vec(mk(4'b0000, 0, 1, 4'b0111, 0, 0, 4'b0000, 4'b1000, 0, 1, 1), $sformatf("err_hold%0d", c));
      chk("err flag", 64'(rsp_error), 64'd1);
      chk("err addr", 64'(rsp_err_addr), 64'hDEAD0);
    end
    run_vec(mk(4'b0000, 0, 1, 4'b1000, 0, 0, 4'b0000, 4'b1000, 1, 1, 1), "err_pop");
    mid_rsp_error = 1'b0;
    mid_rsp_err_addr = '0;
    run_vec(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0), "err_done");

    // Reset with three outstanding and a locked grant (pointer at 0)
    run_vec(mk(4'b0111, 1, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 0, 1), "rs0");
    run_vec(mk(4'b0111, 1, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 1, 1), "rs1");
    run_vec(mk(4'b0111, 1, 0, 4'b0000, 1, 2, 4'b0100, 4'b0000, 0, 2, 1), "rs2");
    run_vec(mk(4'b0001, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 3, 1), "rs_lock0");
    run_vec(mk(4'b0001, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 3, 1), "rs_lock1");
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; mid_req_ready = 1'b0; mid_rsp_valid = 1'b1; rsp_ready = 4'b1111;
    #1;
    chk("rst mid_req_valid", 64'(mid_req_valid), 64'd0);
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst mid_rsp_ready", 64'(mid_rsp_ready), 64'd0);
    chk("rst outstanding", 64'(outstanding), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst stray mid_rsp_ready", 64'(mid_rsp_ready), 64'd0);
    chk("post-rst stray rsp_valid", 64'(rsp_valid), 64'd0);
    #1;
    mid_rsp_valid = 1'b0;
    run_vec(mk(4'b0110, 1, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 0, 1), "post_rst_req");
    exp_q = '{1};
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
